// File: rtl/div_unit_pkg.sv
// div_unit_pkg: constants and types shared by the divider.
//   CNT_W    : width of the iteration counter (covers WIDTH up to 64)
//   div_op_e : latched operation kind, DIVU (unsigned) or DIV (two's complement)
package div_unit_pkg;
   localparam int CNT_W = 6;
   typedef enum logic {OP_DIVU = 1'b0, OP_DIV = 1'b1} div_op_e;
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider, one quotient bit per clock.
//   clk        : sole clock, all state changes on the rising edge
//   resetn     : synchronous active-low reset
//   div_start  : divide request, held high until div_ready is seen
//   div_signed : 1 = signed DIV, 0 = unsigned DIVU
//   div_annul  : flush, aborts any operation and overrides div_start
//   div_opa    : dividend
//   div_opb    : divisor
//   div_result : {remainder, quotient}, updated only when an operation completes
//   div_ready  : one-cycle pulse, div_result valid
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               div_start,
   input  logic               div_signed,
   input  logic               div_annul,
   input  logic [WIDTH-1:0]   div_opa,
   input  logic [WIDTH-1:0]   div_opb,
   output logic [2*WIDTH-1:0] div_result,
   output logic               div_ready
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   div_op_e          op;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH+1:0] diff;
   logic             neg;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   // quo doubles as the dividend shift register: its MSB feeds the remainder
   // while the new quotient bit enters at the LSB.
   always_comb begin
      abs_a    = (div_signed && div_opa[WIDTH-1]) ? -div_opa : div_opa;
      abs_b    = (div_signed && div_opb[WIDTH-1]) ? -div_opb : div_opb;
      diff     = {rem, quo[WIDTH-1]} - {2'b00, dvs};
      neg      = diff[WIDTH+1];
      rem_next = neg ? {rem[WIDTH-1:0], quo[WIDTH-1]} : diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], ~neg};
      // a zero divisor keeps the raw all-ones quotient; the remainder fix-up
      // still restores the dividend's sign, so it equals the dividend
      quo_fix  = (op == OP_DIV && (sign_a ^ sign_b) && dvs != '0) ? -quo_next : quo_next;
      rem_fix  = (op == OP_DIV && sign_a) ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         op         <= OP_DIVU;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         div_ready  <= 1'b0;
         div_result <= '0;
      end else begin
         div_ready <= 1'b0;
         if (div_annul) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (div_start) begin
                  state  <= BUSY;
                  cnt    <= '0;
                  rem    <= '0;
                  quo    <= abs_a;
                  dvs    <= abs_b;
                  op     <= div_op_e'(div_signed);
                  sign_a <= div_signed & div_opa[WIDTH-1];
                  sign_b <= div_signed & div_opb[WIDTH-1];
               end
               BUSY: begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     state      <= DONE;
                     div_result <= {rem_fix, quo_fix};
                  end
               end
               DONE: begin
                  state     <= IDLE;
                  div_ready <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
